sequenciador_rega: RTL and testbench
====================================

// Module: sequenciador_rega
// PURPOSE
//  Actuator side of the irrigation decision logic. Consumes alarme/gotejamento/aspersao
//  and drives the pump and the two valves over time: pump priming, minimum/maximum run
//  time, cooldown, and a fault lockout. Sits between the decision logic and the field
//  relays. All timing is counted in ticks from an internal prescaler.
// PARAMETERS
//  TICK_DIV        50000  clock cycles per tick (>=2)
//  PRIME_TICKS     4      ticks the pump runs with both valves closed before a valve opens
//  MIN_ON_TICKS    10     minimum ticks a valve stays open once opened
//  MAX_ON_TICKS    600    ticks of continuous opening that trip a timeout fault (> MIN_ON_TICKS)
//  COOLDOWN_TICKS  20     ticks with everything off after each run
//  CNT_W           16     tick-timer width; must hold MAX_ON_TICKS
// PORTS
//  clk               in   1   system clock, rising edge
//  reset             in   1   asynchronous, active-high reset
//  alarme            in   1   water level fault/low; inhibits and aborts all actuation
//  gotejamento       in   1   drip irrigation requested
//  aspersao          in   1   sprinkler irrigation requested
//  reconhece         in   1   operator fault acknowledge, sampled while in LOCKOUT
//  bomba             out  1   pump relay
//  valvula_goteja    out  1   drip valve relay
//  valvula_aspersor  out  1   sprinkler valve relay
//  falha_timeout     out  1   sticky: MAX_ON_TICKS exceeded
//  estado            out  3   current FSM state code
// BEHAVIOUR
//  - Reset (async assert): all outputs 0, estado=IDLE, prescaler/timers 0, synchronizers 0.
//  - alarme/gotejamento/aspersao/reconhece pass through 2-flop synchronizers. Outputs are
//    registered with the state (Moore), so an input change shows on outputs at the 3rd edge.
//  - Prescaler counts 0..TICK_DIV-1; tick = 1-cycle pulse at TICK_DIV-1. It restarts at 0 on
//    every state change, so a state held N ticks lasts exactly N*TICK_DIV cycles.
//  - States (estado code): IDLE=0, PRIME=1, DRIP=2, SPRAY=3, COOLDOWN=4, LOCKOUT=5.
//  - IDLE: all off. If alarme: stay. Else if aspersao: PRIME, mode=SPRAY (spray wins when both
//    are set). Else if gotejamento: PRIME, mode=DRIP.
//  - PRIME: bomba=1, valves 0. After PRIME_TICKS ticks, go to the latched mode state.
//  - DRIP/SPRAY: bomba=1 plus the matching valve only, never both. The on-timer counts ticks.
//    * Request of the latched mode dropped and on-timer>=MIN_ON_TICKS: go to COOLDOWN.
//    * The other request has no effect mid-run.
//    * On-timer reaches MAX_ON_TICKS (checked before the request test): go to LOCKOUT and
//      set falha_timeout.
//  - alarme in PRIME/DRIP/SPRAY: go to COOLDOWN at once; MIN_ON_TICKS ignored.
//  - COOLDOWN: all off for COOLDOWN_TICKS ticks, then IDLE. Requests and alarme are ignored.
//  - LOCKOUT: all off; requests ignored. reconhece=1 goes to IDLE and clears falha_timeout.
//    Otherwise only reset leaves this state.
//  - Pump and valve close on the same edge; the pump always opens PRIME_TICKS before a valve.
//  - Unused state codes 6,7: go to IDLE on the next edge, all outputs 0.
// CONFIGURATION
//  REGA_CONTADOR_EN defined: extra output port ciclos_rega[15:0].
//    * Counts runs that end normally (DRIP/SPRAY -> COOLDOWN without alarme).
//    * Saturates at 16'hFFFF; reset to 0; not cleared by reconhece.
//  Not defined: no port and no counter logic; all other behaviour is identical.
// TESTING (TICK_DIV=4, PRIME_TICKS=2, MIN_ON_TICKS=3, MAX_ON_TICKS=8, COOLDOWN_TICKS=2)
//  1. gotejamento=1 held -> estado=1, bomba=1 at edge 3; valvula_goteja=1 exactly 8 cycles later.
//  2. gotejamento=1 and aspersao=1 together -> SPRAY chosen; valvula_goteja never 1.
//  3. Drop gotejamento after 1 tick in DRIP -> valve held to 12 cycles in DRIP; COOLDOWN
//     8 cycles; then IDLE.
//  4. Hold aspersao -> LOCKOUT after 32 cycles in SPRAY, falha=1; requests ignored;
//     reconhece -> IDLE, falha=0.
//  5. alarme=1 mid-SPRAY -> bomba=valvula_aspersor=0 at edge 3; estado=4; no restart while
//     alarme=1.
//  6. reset pulse mid-PRIME, between edges -> all outputs 0 at once; estado=0.
//  7. (REGA_CONTADOR_EN) 3 normal runs + 1 alarm-aborted run -> ciclos_rega=3.

Source files
------------

// File: rtl/sequenciador_rega.sv
// rtl/sequenciador_rega.sv - irrigation actuator sequencer (pump priming, run limits, cooldown, fault lockout)
//
// Purpose: drives the pump and the drip/sprinkler valves from the synchronized
// alarme/gotejamento/aspersao requests. Timing is counted in ticks of an internal
// prescaler that restarts on every state change.
//
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   asynchronous active-high reset
//   alarme            in   water level fault; aborts and inhibits actuation
//   gotejamento       in   drip irrigation request
//   aspersao          in   sprinkler irrigation request
//   reconhece         in   operator acknowledge, leaves LOCKOUT
//   bomba             out  pump relay
//   valvula_goteja    out  drip valve relay
//   valvula_aspersor  out  sprinkler valve relay
//   falha_timeout     out  sticky run-timeout fault
//   estado            out  current state code
//   ciclos_rega       out  count of normally ended runs (only with REGA_CONTADOR_EN)
//
// Optional feature macro: REGA_CONTADOR_EN
module sequenciador_rega #(
  parameter int unsigned TICK_DIV       = 50000,
  parameter int unsigned PRIME_TICKS    = 4,
  parameter int unsigned MIN_ON_TICKS   = 10,
  parameter int unsigned MAX_ON_TICKS   = 600,
  parameter int unsigned COOLDOWN_TICKS = 20,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       alarme,
  input  logic       gotejamento,
  input  logic       aspersao,
  input  logic       reconhece,
  output logic       bomba,
  output logic       valvula_goteja,
  output logic       valvula_aspersor,
  output logic       falha_timeout,
  output logic [2:0] estado
`ifdef REGA_CONTADOR_EN
  ,
  output logic [15:0] ciclos_rega
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    DRIP     = 3'd2,
    SPRAY    = 3'd3,
    COOLDOWN = 3'd4,
    LOCKOUT  = 3'd5
  } state_t;

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [CNT_W:0] PRIME_K   = (CNT_W+1)'(PRIME_TICKS);
  localparam logic [CNT_W:0] MIN_K     = (CNT_W+1)'(MIN_ON_TICKS);
  localparam logic [CNT_W:0] MAX_K     = (CNT_W+1)'(MAX_ON_TICKS);
  localparam logic [CNT_W:0] COOL_K    = (CNT_W+1)'(COOLDOWN_TICKS);

  // Two-flop synchronizers: bit 3 alarme, 2 aspersao, 1 gotejamento, 0 reconhece
  logic [3:0] sync_a, sync_b;
  logic alm_s, asp_s, got_s, rec_s;
  assign alm_s = sync_b[3];
  assign asp_s = sync_b[2];
  assign got_s = sync_b[1];
  assign rec_s = sync_b[0];

  state_t         state, nxt;
  logic [PW-1:0]  presc;
  logic [CNT_W-1:0] tmr;
  logic [CNT_W:0] tmr_eff;
  logic           tick;
  logic           mode_spray;
  logic           req;

  assign tick = (presc == PRESC_MAX);
  // Tick count including the tick completing this cycle, so a limit of N ticks
  // leaves the state exactly on the edge ending the Nth tick.
  assign tmr_eff = {1'b0, tmr} + (CNT_W+1)'(tick);
  assign req = (state == SPRAY) ? asp_s : got_s;
  assign estado = state;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (!alm_s && (asp_s || got_s)) nxt = PRIME;
      end
      PRIME: begin
        if (alm_s)                           nxt = COOLDOWN;
        else if (tick && tmr_eff >= PRIME_K) nxt = mode_spray ? SPRAY : DRIP;
      end
      DRIP, SPRAY: begin
        // Timeout takes precedence over a dropped request on the same edge
        if (alm_s)                        nxt = COOLDOWN;
        else if (tmr_eff >= MAX_K)        nxt = LOCKOUT;
        else if (!req && tmr_eff >= MIN_K) nxt = COOLDOWN;
      end
      COOLDOWN: begin
        if (tick && tmr_eff >= COOL_K) nxt = IDLE;
      end
      LOCKOUT: begin
        if (rec_s) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a           <= '0;
      sync_b           <= '0;
      state            <= IDLE;
      presc            <= '0;
      tmr              <= '0;
      mode_spray       <= 1'b0;
      bomba            <= 1'b0;
      valvula_goteja   <= 1'b0;
      valvula_aspersor <= 1'b0;
      falha_timeout    <= 1'b0;
    end else begin
      sync_a <= {alarme, aspersao, gotejamento, reconhece};
      sync_b <= sync_a;
      state  <= nxt;

      if (nxt != state) begin
        presc <= '0;
        tmr   <= '0;
      end else if (tick) begin
        presc <= '0;
        tmr   <= tmr + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      // Spray wins when both requests are present at start
      if (state == IDLE && nxt == PRIME) mode_spray <= asp_s;

      // Outputs follow the next state so they change on the same edge as estado
      bomba            <= (nxt == PRIME) || (nxt == DRIP) || (nxt == SPRAY);
      valvula_goteja   <= (nxt == DRIP);
      valvula_aspersor <= (nxt == SPRAY);

      if (nxt == LOCKOUT && state != LOCKOUT)   falha_timeout <= 1'b1;
      else if (state == LOCKOUT && nxt == IDLE) falha_timeout <= 1'b0;
    end
  end

`ifdef REGA_CONTADOR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ciclos_rega <= '0;
    end else if ((state == DRIP || state == SPRAY) && nxt == COOLDOWN && !alm_s
                 && ciclos_rega != 16'hFFFF) begin
      ciclos_rega <= ciclos_rega + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sequenciador_rega.sv
// tb/tb_sequenciador_rega.sv - directed self-checking bench for sequenciador_rega
module tb_sequenciador_rega;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       alarme = 1'b0;
  logic       gotejamento = 1'b0;
  logic       aspersao = 1'b0;
  logic       reconhece = 1'b0;
  logic       bomba, valvula_goteja, valvula_aspersor, falha_timeout;
  logic [2:0] estado;
`ifdef REGA_CONTADOR_EN
  logic [15:0] ciclos_rega;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  sequenciador_rega #(
    .TICK_DIV(4), .PRIME_TICKS(2), .MIN_ON_TICKS(3),
    .MAX_ON_TICKS(8), .COOLDOWN_TICKS(2), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .alarme(alarme), .gotejamento(gotejamento),
    .aspersao(aspersao), .reconhece(reconhece), .bomba(bomba),
    .valvula_goteja(valvula_goteja), .valvula_aspersor(valvula_aspersor),
    .falha_timeout(falha_timeout), .estado(estado)
`ifdef REGA_CONTADOR_EN
    , .ciclos_rega(ciclos_rega)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected {estado, bomba, goteja, aspersor, falha}
  task automatic chk(input string tag, input logic [2:0] est, input logic b,
                     input logic g, input logic a, input logic f);
    logic [6:0] obs, exp;
    obs = {estado, bomba, valvula_goteja, valvula_aspersor, falha_timeout};
    exp = {est, b, g, a, f};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

`ifdef REGA_CONTADOR_EN
  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    n_assert++;
    assert (ciclos_rega === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, ciclos_rega, exp);
    end
  endtask
`endif

  initial begin
    // Reset state
    step(3);
    chk("reset_state", 3'd0, 0, 0, 0, 0);
    reset = 1'b0;
    step(3);
    chk("idle_after_reset", 3'd0, 0, 0, 0, 0);

    // Drip: prime at 3rd edge, valve 8 cycles later
    gotejamento = 1'b1;
    step(2);
    chk("drip_sync_delay", 3'd0, 0, 0, 0, 0);
    step(1);
    chk("drip_prime_edge3", 3'd1, 1, 0, 0, 0);
    step(7);
    chk("drip_prime_end", 3'd1, 1, 0, 0, 0);
    step(1);
    chk("drip_valve_open", 3'd2, 1, 1, 0, 0);

    // Drop request after one tick: valve held to minimum, then cooldown
    step(4);
    gotejamento = 1'b0;
    step(7);
    chk("drip_min_hold", 3'd2, 1, 1, 0, 0);
    step(1);
    chk("drip_to_cooldown", 3'd4, 0, 0, 0, 0);
    step(7);
    chk("cooldown_hold", 3'd4, 0, 0, 0, 0);
    step(1);
    chk("cooldown_to_idle", 3'd0, 0, 0, 0, 0);

    // Both requests: spray chosen, then timeout lockout
    gotejamento = 1'b1;
    aspersao    = 1'b1;
    step(3);
    chk("both_prime", 3'd1, 1, 0, 0, 0);
    step(8);
    chk("both_spray", 3'd3, 1, 0, 1, 0);
    for (int i = 1; i < 32; i++) begin
      step(1);
      chk("spray_no_drip_valve", 3'd3, 1, 0, 1, 0);
    end
    step(1);
    chk("spray_timeout_lockout", 3'd5, 0, 0, 0, 1);
    step(20);
    chk("lockout_ignores_requests", 3'd5, 0, 0, 0, 1);
    gotejamento = 1'b0;
    aspersao    = 1'b0;
    reconhece   = 1'b1;
    step(2);
    chk("lockout_ack_sync", 3'd5, 0, 0, 0, 1);
    step(1);
    chk("lockout_ack_idle", 3'd0, 0, 0, 0, 0);
    reconhece = 1'b0;
    step(3);
    chk("idle_after_ack", 3'd0, 0, 0, 0, 0);

    // Alarm mid-spray aborts immediately, no restart while alarm held
    aspersao = 1'b1;
    step(11);
    chk("alarm_spray_start", 3'd3, 1, 0, 1, 0);
    step(5);
    alarme = 1'b1;
    step(2);
    chk("alarm_sync_delay", 3'd3, 1, 0, 1, 0);
    step(1);
    chk("alarm_abort", 3'd4, 0, 0, 0, 0);
    step(8);
    chk("alarm_cooldown_idle", 3'd0, 0, 0, 0, 0);
    step(10);
    chk("alarm_no_restart", 3'd0, 0, 0, 0, 0);
    alarme   = 1'b0;
    aspersao = 1'b0;
    step(3);
    chk("alarm_release_idle", 3'd0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of prime
    gotejamento = 1'b1;
    step(3);
    chk("reset_test_prime", 3'd1, 1, 0, 0, 0);
    step(2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_mid_prime", 3'd0, 0, 0, 0, 0);
    gotejamento = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    chk("idle_after_async_reset", 3'd0, 0, 0, 0, 0);

`ifdef REGA_CONTADOR_EN
    chk_cnt("count_after_reset", 16'd0);
    for (int r = 0; r < 3; r++) begin
      gotejamento = 1'b1;
      step(11);
      chk("count_run_drip", 3'd2, 1, 1, 0, 0);
      gotejamento = 1'b0;
      step(20);
      chk("count_run_idle", 3'd0, 0, 0, 0, 0);
    end
    aspersao = 1'b1;
    step(11);
    alarme   = 1'b1;
    aspersao = 1'b0;
    step(3);
    chk("count_alarm_abort", 3'd4, 0, 0, 0, 0);
    alarme = 1'b0;
    step(8);
    chk("count_alarm_idle", 3'd0, 0, 0, 0, 0);
    chk_cnt("count_three_runs", 16'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
